// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// default frame format, shared by the receiver and the future transmitter.
// Build option: UART_RX_PARITY_EN widens the state enum to include PARITY.
package uart_pkg;

  localparam int OVERSAMPLE      = 16;
  localparam int MID_SAMPLE      = 7;
  localparam int DEFAULT_DBIT    = 8;
  localparam int DEFAULT_SB_TICK = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, one chain per bit, with a
// configurable reset value so idle-high lines come out of reset inactive.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      // Two-stage capture of bit gi; first stage may go metastable.
      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg <= RESET_VAL[gi];
          sync_reg <= RESET_VAL[gi];
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART receiver driven by a 16x oversampling tick. Validates the start bit at
// its centre, shifts data LSB first at bit centres, checks the stop bit and
// strobes rx_done_tick for one clk with dout/frame_err updated in that cycle.
// Build option: define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD
// selects odd parity) and the parity_err output.
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int DBIT    = DEFAULT_DBIT,
  parameter int SB_TICK = DEFAULT_SB_TICK
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            busy
);

  localparam int SW = max_int(4, $clog2(SB_TICK));
  localparam int NW = max_int(1, $clog2(DBIT));

  localparam logic [SW-1:0] S_MID      = SW'(MID_SAMPLE);
  localparam logic [SW-1:0] S_BIT_END  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  rx_state_t        state_reg;
  logic [SW-1:0]    s_reg;
  logic [NW-1:0]    n_reg;
  logic [DBIT-1:0]  b_reg;
  logic             rx_s;
`ifdef UART_RX_PARITY_EN
  logic             par_err_pend_reg;
`endif

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Frame FSM; counters move only on s_tick, outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      b_reg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err       <= 1'b0;
      par_err_pend_reg <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_reg <= START;
            s_reg     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_reg == S_MID) begin
              // A line back high at mid-start is a glitch, not a frame.
              if (!rx_s) begin
                state_reg <= DATA;
                s_reg     <= '0;
                n_reg     <= '0;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_reg == S_BIT_END) begin
              b_reg <= {rx_s, b_reg[DBIT-1:1]};
              s_reg <= '0;
              if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_reg <= PARITY;
`else
                state_reg <= STOP;
`endif
              end else begin
                n_reg <= n_reg + 1'b1;
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s_reg == S_BIT_END) begin
              // Error when the received bit differs from the computed parity.
              par_err_pend_reg <= rx_s ^ (^b_reg) ^ PARITY_ODD;
              s_reg            <= '0;
              state_reg        <= STOP;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s_reg == S_STOP_END) begin
              rx_done_tick <= 1'b1;
              dout         <= b_reg;
              frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err   <= par_err_pend_reg;
`endif
              s_reg        <= '0;
              state_reg    <= IDLE;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench for uart_rx_oversampler: directed frames, glitch, framing error,
// back-to-back frames, mid-frame reset and a randomized frame stream, all
// compared against a frame-level model (sent bytes queued as expected words).
// Build option: UART_RX_PARITY_EN also exercises the parity bit.
module tb_uart_rx_oversampler;

  localparam int M        = 4;
  localparam int BIT_CLKS = 16 * M;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_got_q[$];
  logic       par_exp_q[$];
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] last_dout = 8'h00;
  logic       last_ferr = 1'b0;
  int         strobe_pairs = 0;
  logic       prev_done = 1'b0;
  int         tick_cnt = 0;

  uart_rx_oversampler #(
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Baud generator, mod-M counter: one-clk s_tick every M clocks.
  always @(negedge clk) begin
    if (tick_cnt == M - 1) begin
      tick_cnt = 0;
      s_tick   = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      s_tick   = 1'b0;
    end
  end

  // Capture every received word away from the active edge.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      got_q.push_back({frame_err, dout});
`ifdef UART_RX_PARITY_EN
      par_got_q.push_back(parity_err);
`endif
    end
    if (rx_done_tick && prev_done) strobe_pairs = strobe_pairs + 1;
    prev_done = rx_done_tick;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame on rx; a low stop bit is held low only for its first
  // 40 clks so the receiver's break re-entry sees the line high again.
  task automatic drive_bits(input logic [7:0] data, input bit stop_val,
                            input bit par_val, input int limit);
    logic bits[$];
    int   clks = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef UART_RX_PARITY_EN
    bits.push_back(par_val);
`endif
    bits.push_back(stop_val);
    for (int i = 0; i < bits.size(); i++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (limit >= 0 && clks >= limit) return;
        if (i == bits.size() - 1) rx = (stop_val || c >= 40) ? 1'b1 : 1'b0;
        else rx = bits[i];
        @(negedge clk);
        clks++;
      end
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop_val, input int gap);
    drive_bits(data, stop_val, ^data, -1);
    exp_q.push_back({~stop_val, data});
`ifdef UART_RX_PARITY_EN
    par_exp_q.push_back(1'b0);
`endif
    last_dout = data;
    last_ferr = ~stop_val;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_frames(input string tag);
    logic [8:0] g;
    logic [8:0] e;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      $display("%s: rx dout=%02h frame_err=%0b (expected %02h/%0b)", tag, g[7:0], g[8], e[7:0], e[8]);
      chk({tag, "_dout"}, g[7:0], e[7:0]);
      chk({tag, "_frame_err"}, g[8], e[8]);
    end
`ifdef UART_RX_PARITY_EN
    while (par_got_q.size() > 0 && par_exp_q.size() > 0)
      chk({tag, "_parity_err"}, par_got_q.pop_front(), par_exp_q.pop_front());
    par_got_q.delete();
    par_exp_q.delete();
`endif
    got_q.delete();
    exp_q.delete();
    chk({tag, "_dout_hold"}, dout, last_dout);
    chk({tag, "_ferr_hold"}, frame_err, last_ferr);
  endtask

  initial begin
    logic [7:0] rdata;
    bit         rbad;

    // Reset state.
    repeat (4) @(negedge clk);
    chk("reset_dout", dout, 8'h00);
    chk("reset_done", rx_done_tick, 1'b0);
    chk("reset_ferr", frame_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Single clean frame.
    send_frame(8'h55, 1'b1, 64);
    check_frames("frame_55");
    chk("frame_55_busy", busy, 1'b0);

    // Start glitch of 4 s_ticks is rejected at the mid-start sample.
    rx = 1'b0;
    repeat (4 * M) @(negedge clk);
    chk("glitch_busy_high", busy, 1'b1);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("glitch_busy_low", busy, 1'b0);
    check_frames("glitch");

    // Framing error, then a clean frame clears frame_err.
    send_frame(8'hA3, 1'b0, 128);
    check_frames("ferr_A3");
    send_frame(8'h0F, 1'b1, 64);
    check_frames("clean_0F");

    // Back-to-back frames with zero idle gap.
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h81, 1'b1, 64);
    check_frames("b2b");

    // Reset in the middle of data bit 4.
    drive_bits(8'h3C, 1'b1, ^8'h3C, 5 * BIT_CLKS + 24);
    chk("midreset_busy_before", busy, 1'b1);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_dout", dout, 8'h00);
    chk("midreset_done", rx_done_tick, 1'b0);
    last_dout = 8'h00;
    last_ferr = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_frames("midreset");
    send_frame(8'h3C, 1'b1, 64);
    check_frames("after_reset_3C");

    // Randomized frame stream.
    for (int k = 0; k < 20; k++) begin
      rdata = 8'($urandom);
      rbad  = ($urandom_range(0, 4) == 0);
      if (rbad) send_frame(rdata, 1'b0, 128);
      else      send_frame(rdata, 1'b1, $urandom_range(0, 80));
    end
    repeat (64) @(negedge clk);
    check_frames("random");

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    drive_bits(8'h07, 1'b1, 1'b1, -1);
    exp_q.push_back({1'b0, 8'h07});
    par_exp_q.push_back(1'b0);
    repeat (64) @(negedge clk);
    drive_bits(8'h07, 1'b1, 1'b0, -1);
    exp_q.push_back({1'b0, 8'h07});
    par_exp_q.push_back(1'b1);
    last_dout = 8'h07;
    last_ferr = 1'b0;
    repeat (64) @(negedge clk);
    check_frames("parity_07");
`endif

    chk("no_double_strobe", strobe_pairs, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
